// File: rtl/spi_cmd_tx.sv
// spi_cmd_tx: fetches words 0..region_end from the command buffer and shifts them out as an SPI mode-0 master.
// Optional feature macro SPI_TX_CRC_EN appends a CRC-8 (poly 0x07) byte after the last data word.
module spi_cmd_tx #(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = 32,
    parameter int PTR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_send,
    input  logic [PTR_W-1:0]  region_end,
    output logic [PTR_W-1:0]  mem_ptr,
    output logic              mem_r_en,
    input  logic              mem_done,
    input  logic [WORD_W-1:0] mem_data,
    output logic              cmd_done,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_cs_n
);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(WORD_W) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_CRC    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [PTR_W-1:0]  ptr_r, ptr_s, last_r, last_s;
    logic              r_en_r, r_en_s, cs_n_r, cs_n_s, sclk_r, sclk_s;
    logic              mosi_r, mosi_s, done_r, done_s, busy_r, busy_s;
    logic              phase_r, phase_s;
    logic [WORD_W-1:0] shreg_r, shreg_s;
    logic [BIT_W-1:0]  bit_r, bit_s, bit_last_s;
    logic [DIV_W-1:0]  div_r, div_s;

`ifdef SPI_TX_CRC_EN
    localparam logic [BIT_W-1:0] CRC_LAST = BIT_W'(7);
    logic [7:0] crc_r, crc_s;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        if (crc[7] ^ din) crc8_step = {crc[6:0], 1'b0} ^ 8'h07;
        else              crc8_step = {crc[6:0], 1'b0};
    endfunction
`endif

    // Next-state and next-output logic; phase_r=0 is the sclk-low half of a bit.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        last_s  = last_r;
        r_en_s  = r_en_r;
        cs_n_s  = cs_n_r;
        sclk_s  = sclk_r;
        mosi_s  = mosi_r;
        done_s  = 1'b0;
        busy_s  = busy_r;
        phase_s = phase_r;
        shreg_s = shreg_r;
        bit_s   = bit_r;
        div_s   = div_r;
`ifdef SPI_TX_CRC_EN
        crc_s = crc_r;
        if (state_r == ST_CRC) bit_last_s = CRC_LAST;
        else                   bit_last_s = WORD_LAST;
`else
        bit_last_s = WORD_LAST;
`endif
        case (state_r)
            ST_IDLE: begin
                // busy_r is still high in the cmd_done cycle, so a send there is dropped
                if (cmd_send && !busy_r) begin
                    last_s  = region_end;
                    ptr_s   = {PTR_W{1'b0}};
                    r_en_s  = 1'b1;
                    cs_n_s  = 1'b0;
                    busy_s  = 1'b1;
`ifdef SPI_TX_CRC_EN
                    crc_s   = 8'h00;
`endif
                    state_s = ST_FETCH;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            ST_FETCH: begin
                if (mem_done && r_en_r) begin
                    shreg_s = mem_data;
                    mosi_s  = mem_data[WORD_W-1];
                    r_en_s  = 1'b0;
                    bit_s   = {BIT_W{1'b0}};
                    div_s   = {DIV_W{1'b0}};
                    phase_s = 1'b0;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_FETCH;
                end
            end
`ifdef SPI_TX_CRC_EN
            ST_SHIFT, ST_CRC: begin
`else
            ST_SHIFT: begin
`endif
                if (div_r != DIV_LAST) begin
                    div_s = div_r + DIV_ONE;
                end else if (!phase_r) begin
                    div_s   = {DIV_W{1'b0}};
                    phase_s = 1'b1;
                    sclk_s  = 1'b1;
`ifdef SPI_TX_CRC_EN
                    if (state_r == ST_SHIFT) crc_s = crc8_step(crc_r, mosi_r);
                    else                     crc_s = crc_r;
`endif
                end else begin
                    div_s   = {DIV_W{1'b0}};
                    phase_s = 1'b0;
                    sclk_s  = 1'b0;
                    if (bit_r != bit_last_s) begin
                        bit_s   = bit_r + BIT_ONE;
                        shreg_s = {shreg_r[WORD_W-2:0], 1'b0};
                        mosi_s  = shreg_r[WORD_W-2];
                    end else if (ptr_r != last_r) begin
                        ptr_s   = ptr_r + PTR_ONE;
                        r_en_s  = 1'b1;
                        state_s = ST_FETCH;
                    end else begin
`ifdef SPI_TX_CRC_EN
                        if (state_r == ST_SHIFT) begin
                            shreg_s = {crc_r, {(WORD_W-8){1'b0}}};
                            mosi_s  = crc_r[7];
                            bit_s   = {BIT_W{1'b0}};
                            state_s = ST_CRC;
                        end else begin
                            mosi_s  = 1'b0;
                            state_s = ST_FINISH;
                        end
`else
                        mosi_s  = 1'b0;
                        state_s = ST_FINISH;
`endif
                    end
                end
            end
            ST_FINISH: begin
                if (div_r != DIV_LAST) begin
                    div_s = div_r + DIV_ONE;
                end else begin
                    div_s   = {DIV_W{1'b0}};
                    cs_n_s  = 1'b1;
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                r_en_s  = 1'b0;
                cs_n_s  = 1'b1;
                sclk_s  = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= {PTR_W{1'b0}};
            last_r  <= {PTR_W{1'b0}};
            r_en_r  <= 1'b0;
            cs_n_r  <= 1'b1;
            sclk_r  <= 1'b0;
            mosi_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            phase_r <= 1'b0;
            shreg_r <= {WORD_W{1'b0}};
            bit_r   <= {BIT_W{1'b0}};
            div_r   <= {DIV_W{1'b0}};
`ifdef SPI_TX_CRC_EN
            crc_r   <= 8'h00;
`endif
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            last_r  <= last_s;
            r_en_r  <= r_en_s;
            cs_n_r  <= cs_n_s;
            sclk_r  <= sclk_s;
            mosi_r  <= mosi_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
            phase_r <= phase_s;
            shreg_r <= shreg_s;
            bit_r   <= bit_s;
            div_r   <= div_s;
`ifdef SPI_TX_CRC_EN
            crc_r   <= crc_s;
`endif
        end
    end

    assign mem_ptr  = ptr_r;
    assign mem_r_en = r_en_r;
    assign cmd_done = done_r;
    assign busy     = busy_r;
    assign spi_sclk = sclk_r;
    assign spi_mosi = mosi_r;
    assign spi_cs_n = cs_n_r;

endmodule

// File: tb/tb_spi_cmd_tx.sv
// Testbench for spi_cmd_tx: randomized buffer responder, bit-stream capture on sclk rising edges,
// and a queue-based reference of the expected frame (CRC byte appended when SPI_TX_CRC_EN is defined).
module tb_spi_cmd_tx;
    localparam int CLK_DIV = 2;
    localparam int WORD_W  = 32;
    localparam int PTR_W   = 4;
`ifdef SPI_TX_CRC_EN
    localparam int CRC_BITS = 8;
`else
    localparam int CRC_BITS = 0;
`endif

    logic              clk, rst, cmd_send;
    logic [PTR_W-1:0]  region_end, mem_ptr;
    logic              mem_r_en, mem_done;
    logic [WORD_W-1:0] mem_data;
    logic              cmd_done, busy, spi_sclk, spi_mosi, spi_cs_n;

    int n_cmp, n_bad;
    logic [WORD_W-1:0] words [16];
    bit   bits_q[$];
    bit   exp_q[$];
    int   ptr_log[$];
    int   done_cnt, viol_cnt;
    int   max_delay, wait_cnt;
    logic idle_poke;
    logic prev_sclk, prev_mosi;
    int   hi_len, lo_len, since_mosi;

    spi_cmd_tx #(.CLK_DIV(CLK_DIV), .WORD_W(WORD_W), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .cmd_send(cmd_send), .region_end(region_end),
        .mem_ptr(mem_ptr), .mem_r_en(mem_r_en), .mem_done(mem_done), .mem_data(mem_data),
        .cmd_done(cmd_done), .busy(busy), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Command buffer model: answers each read request after 0..max_delay extra clocks
    initial begin
        mem_done = 1'b0;
        mem_data = '0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            if (idle_poke) begin
                mem_done = 1'b1;
                mem_data = WORD_W'($urandom);
            end else if (mem_r_en) begin
                if (wait_cnt == 0) begin
                    mem_done = 1'b1;
                    mem_data = words[mem_ptr];
                    ptr_log.push_back(int'(mem_ptr));
                    wait_cnt = (max_delay == 0) ? 0 : int'($urandom_range(max_delay, 0));
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // SPI pin monitor: captures bits at sclk rise and counts protocol violations
    initial begin
        prev_sclk = 1'b0; prev_mosi = 1'b0;
        hi_len = 0; lo_len = 1000; since_mosi = 1000;
        forever begin
            @(negedge clk);
            if (spi_mosi !== prev_mosi) since_mosi = 0;
            else since_mosi++;
            if (spi_sclk === 1'b1) begin
                if (prev_sclk !== 1'b1) begin
                    bits_q.push_back(spi_mosi);
                    if (spi_cs_n !== 1'b0) viol_cnt++;
                    if (lo_len < CLK_DIV || since_mosi < CLK_DIV) viol_cnt++;
                    hi_len = 0;
                end else if (spi_mosi !== prev_mosi) begin
                    viol_cnt++;
                end
                hi_len++;
            end else begin
                if (prev_sclk === 1'b1) begin
                    if (hi_len != CLK_DIV) viol_cnt++;
                    lo_len = 0;
                end
                lo_len++;
            end
            if (mem_r_en === 1'b1 && spi_sclk !== 1'b0) viol_cnt++;
            if (cmd_done === 1'b1) done_cnt++;
            prev_sclk = spi_sclk;
            prev_mosi = spi_mosi;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog");
    end

    function automatic void build_expected(input int re);
`ifdef SPI_TX_CRC_EN
        logic [7:0] crc;
`endif
        exp_q.delete();
        for (int w = 0; w <= re; w++)
            for (int i = WORD_W - 1; i >= 0; i--) exp_q.push_back(words[w][i]);
`ifdef SPI_TX_CRC_EN
        crc = 8'h00;
        foreach (exp_q[i]) begin
            if (crc[7] ^ exp_q[i]) crc = {crc[6:0], 1'b0} ^ 8'h07;
            else crc = {crc[6:0], 1'b0};
        end
        for (int i = 7; i >= 0; i--) exp_q.push_back(crc[i]);
`endif
    endfunction

    function automatic int bit_errs();
        int n = 0;
        if (bits_q.size() != exp_q.size()) n++;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= bits_q.size() || bits_q[i] != exp_q[i]) n++;
        return n;
    endfunction

    task automatic clear_mon();
        bits_q.delete(); ptr_log.delete();
        done_cnt = 0; viol_cnt = 0;
    endtask

    task automatic start_cmd(input logic [PTR_W-1:0] re, input int dly);
        max_delay = dly;
        build_expected(int'(re));
        @(posedge clk); #1;
        clear_mon();
        cmd_send = 1'b1; region_end = re;
        @(posedge clk); #1;
        cmd_send = 1'b0; region_end = PTR_W'($urandom);
    endtask

    task automatic wait_done(output int lat, output bit tmo);
        lat = 0; tmo = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            lat++;
            if (cmd_done === 1'b1) begin tmo = 1'b0; break; end
        end
    endtask

    task automatic finish_frame(output int lat, output bit tmo, output logic b_done, output logic b_after);
        wait_done(lat, tmo);
        b_done = busy;
        @(negedge clk);
        b_after = busy;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (spi_cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b expected 1", spi_cs_n); end
        n_cmp++; if (spi_sclk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b expected 0", spi_sclk); end
        n_cmp++; if (spi_mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b expected 0", spi_mosi); end
        n_cmp++; if (mem_r_en !== 1'b0) begin n_bad++; $display("FAIL reset_r_en: got %b expected 0", mem_r_en); end
        n_cmp++; if (mem_ptr !== 4'd0) begin n_bad++; $display("FAIL reset_ptr: got %0d expected 0", mem_ptr); end
        n_cmp++; if (cmd_done !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_done: got %b expected 0", cmd_done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_idle_mem_done();
        int bad = 0;
        @(posedge clk); #1;
        idle_poke = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (mem_r_en !== 1'b0 || busy !== 1'b0 || spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 ||
                spi_mosi !== 1'b0 || cmd_done !== 1'b0 || mem_ptr !== 4'd0) bad++;
        end
        @(posedge clk); #1;
        idle_poke = 1'b0;
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL idle_mem_done: got %0d disturbed cycles expected 0", bad); end
    endtask

    task automatic test_single_word();
        int lat, exp_lat; bit tmo; logic b_done, b_after;
        words[0] = 32'hA5A50F0F;
        start_cmd(4'd0, 0);
        finish_frame(lat, tmo, b_done, b_after);
        exp_lat = 1 + (WORD_W + CRC_BITS) * 2 * CLK_DIV + CLK_DIV + 1;
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL single_timeout: got timeout expected cmd_done"); end
        n_cmp++; if (bit_errs() !== 0) begin n_bad++; $display("FAIL single_bits: got %0d bits with %0d errors expected %0d bits exact", bits_q.size(), bit_errs(), exp_q.size()); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL single_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (viol_cnt !== 0) begin n_bad++; $display("FAIL single_protocol: got %0d violations expected 0", viol_cnt); end
        n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL single_latency: got %0d expected %0d", lat, exp_lat); end
        n_cmp++; if (b_done !== 1'b1) begin n_bad++; $display("FAIL single_busy_at_done: got %b expected 1", b_done); end
        n_cmp++; if (b_after !== 1'b0) begin n_bad++; $display("FAIL single_busy_after: got %b expected 0", b_after); end
    endtask

    task automatic test_full_region();
        int lat, ptr_bad; bit tmo; logic b_done, b_after;
        for (int i = 0; i < 16; i++) words[i] = WORD_W'(i);
        start_cmd(4'd15, 5);
        finish_frame(lat, tmo, b_done, b_after);
        ptr_bad = (ptr_log.size() == 16) ? 0 : 1;
        foreach (ptr_log[i]) if (ptr_log[i] != i) ptr_bad++;
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL full_timeout: got timeout expected cmd_done"); end
        n_cmp++; if (bits_q.size() !== WORD_W * 16 + CRC_BITS) begin n_bad++; $display("FAIL full_bit_count: got %0d expected %0d", bits_q.size(), WORD_W * 16 + CRC_BITS); end
        n_cmp++; if (bit_errs() !== 0) begin n_bad++; $display("FAIL full_bits: got %0d errors expected 0", bit_errs()); end
        n_cmp++; if (ptr_bad !== 0) begin n_bad++; $display("FAIL full_ptr_sequence: got %0d requests with %0d errors expected 16 in order", ptr_log.size(), ptr_bad); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL full_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (viol_cnt !== 0) begin n_bad++; $display("FAIL full_protocol: got %0d violations expected 0", viol_cnt); end
    endtask

    task automatic test_random_frames();
        int lat; bit tmo; logic b_done, b_after; logic [PTR_W-1:0] re;
        for (int it = 0; it < 4; it++) begin
            re = PTR_W'($urandom_range(6, 0));
            for (int i = 0; i < 16; i++) words[i] = WORD_W'($urandom);
            start_cmd(re, 3);
            finish_frame(lat, tmo, b_done, b_after);
            n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL rand%0d_timeout: got timeout expected cmd_done", it); end
            n_cmp++; if (bit_errs() !== 0) begin n_bad++; $display("FAIL rand%0d_bits: got %0d bits with %0d errors expected %0d exact", it, bits_q.size(), bit_errs(), exp_q.size()); end
            n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rand%0d_done_count: got %0d expected 1", it, done_cnt); end
            n_cmp++; if (viol_cnt !== 0) begin n_bad++; $display("FAIL rand%0d_protocol: got %0d violations expected 0", it, viol_cnt); end
        end
    endtask

    task automatic test_ignore_resend();
        int lat; bit tmo; logic b_done, b_after;
        for (int i = 0; i < 16; i++) words[i] = WORD_W'($urandom);
        start_cmd(4'd1, 2);
        for (int i = 0; i < 2000 && bits_q.size() < 20; i++) @(negedge clk);
        @(posedge clk); #1;
        cmd_send = 1'b1; region_end = 4'd3;
        @(posedge clk); #1;
        cmd_send = 1'b0;
        finish_frame(lat, tmo, b_done, b_after);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL ignore_timeout: got timeout expected cmd_done"); end
        n_cmp++; if (bits_q.size() !== 2 * WORD_W + CRC_BITS) begin n_bad++; $display("FAIL ignore_bit_count: got %0d expected %0d", bits_q.size(), 2 * WORD_W + CRC_BITS); end
        n_cmp++; if (bit_errs() !== 0) begin n_bad++; $display("FAIL ignore_bits: got %0d errors expected 0", bit_errs()); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int lat; bit tmo; logic b_done, b_after;
        words[0] = WORD_W'($urandom);
        start_cmd(4'd0, 0);
        for (int i = 0; i < 2000 && bits_q.size() < 10; i++) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (spi_cs_n !== 1'b1) begin n_bad++; $display("FAIL midrst_cs_n: got %b expected 1", spi_cs_n); end
        n_cmp++; if (spi_sclk !== 1'b0) begin n_bad++; $display("FAIL midrst_sclk: got %b expected 0", spi_sclk); end
        n_cmp++; if (mem_r_en !== 1'b0) begin n_bad++; $display("FAIL midrst_r_en: got %b expected 0", mem_r_en); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        repeat (20) @(negedge clk);
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d expected 0", done_cnt); end
        words[0] = WORD_W'($urandom);
        start_cmd(4'd0, 1);
        finish_frame(lat, tmo, b_done, b_after);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL midrst_resume_timeout: got timeout expected cmd_done"); end
        n_cmp++; if (bit_errs() !== 0) begin n_bad++; $display("FAIL midrst_resume_bits: got %0d errors expected 0", bit_errs()); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL midrst_resume_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int lat; bit tmo;
        words[0] = WORD_W'($urandom);
        start_cmd(4'd0, 1);
        wait_done(lat, tmo);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL b2b_first_timeout: got timeout expected cmd_done"); end
        n_cmp++; if (bit_errs() !== 0) begin n_bad++; $display("FAIL b2b_first_bits: got %0d errors expected 0", bit_errs()); end
        cmd_send = 1'b1; region_end = 4'd0;
        words[0] = WORD_W'($urandom);
        build_expected(0);
        @(posedge clk); #1;
        clear_mon();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_send_in_done_cycle: got busy=%b expected 0", busy); end
        @(posedge clk); #1;
        cmd_send = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_after_done: got busy=%b expected 1", busy); end
        wait_done(lat, tmo);
        repeat (4) @(negedge clk);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL b2b_second_timeout: got timeout expected cmd_done"); end
        n_cmp++; if (bit_errs() !== 0) begin n_bad++; $display("FAIL b2b_second_bits: got %0d bits with %0d errors expected %0d exact", bits_q.size(), bit_errs(), exp_q.size()); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL b2b_second_done_count: got %0d expected 1", done_cnt); end
    endtask

`ifdef SPI_TX_CRC_EN
    task automatic test_crc();
        int lat; bit tmo; logic b_done, b_after; logic [7:0] tail;
        words[0] = 32'h00000001;
        start_cmd(4'd0, 0);
        finish_frame(lat, tmo, b_done, b_after);
        tail = 8'h00;
        if (bits_q.size() >= 8)
            for (int i = 0; i < 8; i++) tail = {tail[6:0], 1'(bits_q[bits_q.size() - 8 + i])};
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL crc_timeout: got timeout expected cmd_done"); end
        n_cmp++; if (bits_q.size() !== WORD_W + 8) begin n_bad++; $display("FAIL crc_bit_count: got %0d expected %0d", bits_q.size(), WORD_W + 8); end
        n_cmp++; if (tail !== 8'h07) begin n_bad++; $display("FAIL crc_byte: got %02h expected 07", tail); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL crc_done_count: got %0d expected 1", done_cnt); end
    endtask
`endif

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; cmd_send = 1'b0; region_end = '0;
        idle_poke = 1'b0; max_delay = 0;
        done_cnt = 0; viol_cnt = 0;
        for (int i = 0; i < 16; i++) words[i] = '0;
        test_reset();
        test_idle_mem_done();
        test_single_word();
        test_full_region();
        test_random_frames();
        test_ignore_resend();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef SPI_TX_CRC_EN
        test_crc();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
